pixel_dispatcher: RTL

PIXEL_DISPATCHER -- requirements
Module: pixel_dispatcher

---
 rtl/pixel_dispatcher.sv | 116 +++++++++++
 1 files changed

// File: rtl/pixel_dispatcher.sv
// Round-robin pixel scheduler: issues raster coordinates to NUM_ENG depth engines
// and retires their results in raster order through a valid/ready output.
module pixel_dispatcher #(
    parameter int NUM_ENG = 4,
    parameter int X_SIZE  = 640,
    parameter int Y_SIZE  = 480
) (
    input  logic                 out_stream_aclk,
    input  logic                 periph_resetn,
    input  logic                 enable,
    output logic [NUM_ENG-1:0]   eng_start,
    output logic [9:0]           eng_x,
    output logic [8:0]           eng_y,
    input  logic [NUM_ENG-1:0]   eng_done,
    input  logic [8*NUM_ENG-1:0] eng_depth,
    output logic [7:0]           pix_depth,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic                 pix_sof,
    output logic                 pix_eol,
    output logic                 busy,
    output logic                 err_spurious
);

    localparam int PW = $clog2(NUM_ENG);
    localparam logic [9:0] X_LAST = 10'(X_SIZE - 1);
    localparam logic [8:0] Y_LAST = 9'(Y_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } slot_state_t;

    slot_state_t   slot_state [NUM_ENG];
    logic [7:0]    slot_depth [NUM_ENG];
    logic          slot_sof   [NUM_ENG];
    logic          slot_eol   [NUM_ENG];

    logic [PW-1:0] iss_ptr;
    logic [PW-1:0] ret_ptr;
    logic [9:0]    x;
    logic [8:0]    y;
    logic          issue;
    logic          retire;

    // Both decisions look only at registered slot state, so a slot freed by
    // retire cannot be reissued until the following cycle.
    assign issue  = enable && (slot_state[iss_ptr] == IDLE);
    assign retire = pix_valid && pix_ready;

    assign pix_valid = (slot_state[ret_ptr] == DONE);
    assign pix_depth = slot_depth[ret_ptr];
    assign pix_sof   = slot_sof[ret_ptr];
    assign pix_eol   = slot_eol[ret_ptr];

    always_comb begin
        busy = 1'b0;
        for (int unsigned k = 0; k < NUM_ENG; k++) begin
            if (slot_state[k] != IDLE) busy = 1'b1;
        end
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            for (int unsigned k = 0; k < NUM_ENG; k++) begin
                slot_state[k] <= IDLE;
                slot_depth[k] <= '0;
                slot_sof[k]   <= 1'b0;
                slot_eol[k]   <= 1'b0;
            end
            iss_ptr      <= '0;
            ret_ptr      <= '0;
            x            <= '0;
            y            <= '0;
            eng_start    <= '0;
            eng_x        <= '0;
            eng_y        <= '0;
            err_spurious <= 1'b0;
        end else begin
            eng_start <= '0;
            if (issue) begin
                eng_start[iss_ptr]  <= 1'b1;
                eng_x               <= x;
                eng_y               <= y;
                slot_state[iss_ptr] <= BUSY;
                slot_sof[iss_ptr]   <= (x == '0) && (y == '0);
                slot_eol[iss_ptr]   <= (x == X_LAST);
                iss_ptr             <= iss_ptr + PW'(1);
                if (x == X_LAST) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + 9'd1;
                end else begin
                    x <= x + 10'd1;
                end
            end
            if (retire) begin
                slot_state[ret_ptr] <= IDLE;
                ret_ptr             <= ret_ptr + PW'(1);
            end
            // Issue, retire and capture each require a different prior state,
            // so they never target the same slot in one cycle.
            for (int unsigned k = 0; k < NUM_ENG; k++) begin
                if (eng_done[k]) begin
                    if (slot_state[k] == BUSY) begin
                        slot_depth[k] <= eng_depth[8*k +: 8];
                        slot_state[k] <= DONE;
                    end else begin
                        err_spurious <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
